// File: rtl/tetris_vga_pkg.sv
// tetris_vga_pkg: shared colour codes, default screen size, renderer FSM states and address-width helper
package tetris_vga_pkg;
   localparam logic [2:0] BLACK = 3'd0, BLUE = 3'd1, GREEN = 3'd2, CYAN = 3'd3;
   localparam logic [2:0] RED = 3'd4, MAGENTA = 3'd5, YELLOW = 3'd6, WHITE = 3'd7;
   localparam int SCREEN_W_DEF = 160;
   localparam int SCREEN_H_DEF = 120;
   typedef enum logic [2:0] {IDLE, CLEAR, DRAW, FLUSH, DONE} state_t;
   // Address width for n entries, never below 1 bit so a 1-wide board still gets a port.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/render_cell_scanner.sv
// render_cell_scanner: nested px/py/col/row counters with last-pixel flag
// Ports: clock, reset (sync, high); init forces all counters to 0; en advances one pixel;
//        px_max/col_max/row_max are the inclusive limits (px_max also bounds py);
//        px, py, col, row are the current scan position; last flags the final position.
module render_cell_scanner
   import tetris_vga_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       init,
   input  logic       en,
   input  logic [3:0] px_max,
   input  logic [7:0] col_max,
   input  logic [6:0] row_max,
   output logic [3:0] px,
   output logic [3:0] py,
   output logic [7:0] col,
   output logic [6:0] row,
   output logic       last
);
   logic px_end, py_end, col_end, row_end;
   always_comb begin
      px_end  = px == px_max;
      py_end  = py == px_max;
      col_end = col == col_max;
      row_end = row == row_max;
      last    = px_end && py_end && col_end && row_end;
   end
   // At the final position every counter wraps to 0, so a following pass starts clean.
   always_ff @(posedge clock)
      if (reset || init) begin
         px  <= '0;
         py  <= '0;
         col <= '0;
         row <= '0;
      end else if (en) begin
         px <= px_end ? '0 : px + 1'b1;
         if (px_end) py <= py_end ? '0 : py + 1'b1;
         if (px_end && py_end) col <= col_end ? '0 : col + 1'b1;
         if (px_end && py_end && col_end) row <= row_end ? '0 : row + 1'b1;
      end
endmodule

// File: rtl/tetris_board_renderer.sv
// tetris_board_renderer: streams an optional clear pass and the board cells to the VGA pixel-write port
// Ports: clock, reset (sync, high); start/clear_first/clear_colour request a frame;
//        cell_row/cell_col address the board RAM, cell_data returns one cycle later;
//        x, y, colour, plot drive the pixel writer; busy spans the frame, done pulses once at the end.
module tetris_board_renderer
   import tetris_vga_pkg::*;
#(
   parameter int         COLS         = 10,
   parameter int         ROWS         = 20,
   parameter int         BLOCK_SIZE   = 6,
   parameter int         X_START      = 50,
   parameter int         Y_START      = 0,
   parameter int         SCREEN_W     = SCREEN_W_DEF,
   parameter int         SCREEN_H     = SCREEN_H_DEF,
   parameter int         GRID_LINES   = 0,
   parameter logic [2:0] GRID_COLOUR  = BLACK,
   parameter logic [2:0] EMPTY_COLOUR = WHITE
)(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     clear_first,
   input  logic [2:0]               clear_colour,
   output logic [clog2(ROWS)-1:0]   cell_row,
   output logic [clog2(COLS)-1:0]   cell_col,
   input  logic [2:0]               cell_data,
   output logic [7:0]               x,
   output logic [6:0]               y,
   output logic [2:0]               colour,
   output logic                     plot,
   output logic                     busy,
   output logic                     done
);
   localparam int RW = clog2(ROWS);
   localparam int CW = clog2(COLS);
   state_t     state, state_n;
   logic [3:0] px, py, px_max;
   logic [7:0] col, col_max;
   logic [6:0] row, row_max;
   logic       last, scan_en;
   logic [2:0] clr_colour;
   logic       v1, clr1, grid1;
   logic [7:0] x1;
   logic [6:0] y1;

   render_cell_scanner u_scan (
      .clock   (clock),
      .reset   (reset),
      .init    (state == IDLE),
      .en      (scan_en),
      .px_max  (px_max),
      .col_max (col_max),
      .row_max (row_max),
      .px      (px),
      .py      (py),
      .col     (col),
      .row     (row),
      .last    (last)
   );

   always_ff @(posedge clock)
      state <= reset ? IDLE : state_n;

   // done is still high in the first IDLE cycle; gating on it rejects a start issued alongside done.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start && !done) state_n = clear_first ? CLEAR : DRAW;
         CLEAR:   if (last) state_n = DRAW;
         DRAW:    if (last) state_n = FLUSH;
         FLUSH:   state_n = DONE;
         default: state_n = IDLE;
      endcase
   end

   // The clear pass reuses the scanner as 1-pixel cells over the whole screen.
   always_comb begin
      scan_en  = state == CLEAR || state == DRAW;
      px_max   = state == CLEAR ? 4'd0 : 4'(BLOCK_SIZE - 1);
      col_max  = state == CLEAR ? 8'(SCREEN_W - 1) : 8'(COLS - 1);
      row_max  = state == CLEAR ? 7'(SCREEN_H - 1) : 7'(ROWS - 1);
      cell_row = state == DRAW ? row[RW-1:0] : '0;
      cell_col = state == DRAW ? col[CW-1:0] : '0;
   end

   // Stage 1 lines up pixel coordinates with the RAM read; stage 2 is the output register.
   always_ff @(posedge clock)
      if (reset) begin
         clr_colour <= '0;
         v1         <= 1'b0;
         clr1       <= 1'b0;
         grid1      <= 1'b0;
         x1         <= '0;
         y1         <= '0;
         x          <= '0;
         y          <= '0;
         colour     <= '0;
         plot       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         if (state == IDLE && state_n != IDLE) clr_colour <= clear_colour;
         v1     <= scan_en;
         clr1   <= state == CLEAR;
         grid1  <= GRID_LINES != 0 && (px == px_max || py == px_max);
         x1     <= state == CLEAR ? col : 8'(X_START + col * BLOCK_SIZE + px);
         y1     <= state == CLEAR ? row : 7'(Y_START + row * BLOCK_SIZE + py);
         x      <= x1;
         y      <= y1;
         plot   <= v1;
         colour <= !v1 ? 3'd0 : clr1 ? clr_colour : grid1 ? GRID_COLOUR :
                   cell_data == '0 ? EMPTY_COLOUR : cell_data;
         busy   <= state_n != IDLE;
         done   <= state == DONE;
      end
endmodule
